// File: rtl/remote_cmd_pkg.sv
// Shared constants for the remote command UART transmitter: state encoding,
// motor/servo wire codes and the command-byte packer.
package remote_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  localparam int unsigned CMD_W  = 8;
  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] MOTOR_HALT     = 3'b000;
  localparam logic [CODE_W-1:0] MOTOR_FORWARD  = 3'b011;
  localparam logic [CODE_W-1:0] MOTOR_BACKWARD = 3'b110;

  localparam logic [CODE_W-1:0] SERVO_HOLD     = 3'b000;
  localparam logic [CODE_W-1:0] SERVO_LEFT     = 3'b011;
  localparam logic [CODE_W-1:0] SERVO_RIGHT    = 3'b110;
  localparam logic [CODE_W-1:0] SERVO_STRAIGHT = 3'b101;

  typedef struct packed {
    logic [CODE_W-1:0] motor;
    logic [CODE_W-1:0] servo;
    logic [1:0]        pad;
  } cmd_byte_t;

  // Map the 2-bit request fields onto the on-wire command byte.
  function automatic logic [CMD_W-1:0] encode_cmd(input logic [1:0] motor,
                                                  input logic [1:0] servo);
    cmd_byte_t c;
    case (motor)
      2'd1:    c.motor = MOTOR_FORWARD;
      2'd2:    c.motor = MOTOR_BACKWARD;
      default: c.motor = MOTOR_HALT;
    endcase
    case (servo)
      2'd1:    c.servo = SERVO_LEFT;
      2'd2:    c.servo = SERVO_RIGHT;
      2'd3:    c.servo = SERVO_STRAIGHT;
      default: c.servo = SERVO_HOLD;
    endcase
    c.pad = 2'b00;
    return c;
  endfunction

endpackage

// File: rtl/remote_cmd_baud.sv
// Bit-period timer: bit_tick_o is high for the last cycle of every DIV-cycle
// bit window, with the window realigned by restart_i.
module remote_cmd_baud #(
  parameter int unsigned DIV = 108
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || (cnt_q == CNT_LAST)) cnt_d = '0;
  end

  // Tick is registered off the next count so it lines up with cnt_q == DIV-1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

  assign bit_tick_o = tick_q;

endmodule

// File: rtl/remote_cmd_tx.sv
// Remote command UART transmitter (8N1). Define REMOTE_CMD_KEEPALIVE_EN to
// resend the last command after KEEPALIVE_CYCLES consecutive idle cycles.
module remote_cmd_tx
  import remote_cmd_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD_RATE        = 921600,
  parameter int unsigned KEEPALIVE_CYCLES = 10_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_motor,
  input  logic [1:0] req_servo,
  output logic       tx_pin,
  output logic       busy
);

  localparam int unsigned DIV   = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned BIT_W = 3;

  state_e             state_q;
  logic               tx_pin_q;
  logic               busy_q;
  logic               req_ready_q;
  logic [CMD_W-1:0]   shift_q;
  logic [CMD_W-1:0]   last_cmd_q;
  logic [BIT_W-1:0]   bit_cnt_q;

  logic               bit_tick;
  logic               accept_c;
  logic               ka_fire_c;
  logic               start_c;
  logic [CMD_W-1:0]   next_byte_c;

  assign accept_c    = req_valid && req_ready_q;
  assign start_c     = (state_q == ST_IDLE) && (accept_c || ka_fire_c);
  assign next_byte_c = accept_c ? encode_cmd(req_motor, req_servo) : last_cmd_q;

  remote_cmd_baud #(
    .DIV(DIV)
  ) u_baud (
    .clk_i     (sys_clk),
    .rst_i     (rst),
    .restart_i (start_c),
    .bit_tick_o(bit_tick)
  );

`ifdef REMOTE_CMD_KEEPALIVE_EN
  localparam int unsigned KA_W = $clog2(KEEPALIVE_CYCLES + 1);
  localparam logic [KA_W-1:0] KA_LAST = KA_W'(KEEPALIVE_CYCLES - 1);

  logic [KA_W-1:0] idle_cnt_q;

  // A real request at the expiry cycle takes priority via next_byte_c.
  assign ka_fire_c = (state_q == ST_IDLE) && (idle_cnt_q == KA_LAST);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else if ((state_q != ST_IDLE) || start_c) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + KA_W'(1);
    end
  end
`else
  logic unused_keepalive;

  assign ka_fire_c        = 1'b0;
  assign unused_keepalive = ^{32'(KEEPALIVE_CYCLES), last_cmd_q};
`endif

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_pin_q    <= 1'b1;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
      shift_q     <= '0;
      last_cmd_q  <= '0;
      bit_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            state_q     <= ST_START;
            tx_pin_q    <= 1'b0;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            shift_q     <= next_byte_c;
            last_cmd_q  <= next_byte_c;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state_q   <= ST_DATA;
            tx_pin_q  <= shift_q[0];
            shift_q   <= {1'b0, shift_q[CMD_W-1:1]};
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q == BIT_W'(CMD_W - 1)) begin
              state_q  <= ST_STOP;
              tx_pin_q <= 1'b1;
            end else begin
              tx_pin_q  <= shift_q[0];
              shift_q   <= {1'b0, shift_q[CMD_W-1:1]};
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_pin    = tx_pin_q;
  assign busy      = busy_q;
  assign req_ready = req_ready_q;

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Self-checking bench for remote_cmd_tx; keepalive scenarios are exercised
// when REMOTE_CMD_KEEPALIVE_EN is defined.
module tb_remote_cmd_tx;

  localparam int DIV   = 108;
  localparam int FRAME = 10 * DIV;
  localparam int KA    = 200;

  logic       sys_clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_motor;
  logic [1:0] req_servo;
  logic       tx_pin;
  logic       busy;

  int checks = 0;
  int errors = 0;

  remote_cmd_tx #(
    .SYS_CLK_FREQ    (100_000_000),
    .BAUD_RATE       (921600),
    .KEEPALIVE_CYCLES(KA)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_motor(req_motor),
    .req_servo(req_servo),
    .tx_pin   (tx_pin),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference encoding taken straight from the command code tables.
  function automatic logic [7:0] model_byte(input int m, input int s);
    int mc[4] = '{0, 3, 6, 0};
    int sc[4] = '{0, 3, 6, 5};
    return 8'((mc[m] << 5) | (sc[s] << 2));
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    assert ({tx_pin, busy, req_ready} === 3'b101)
      else begin
        errors++;
        $error("FAIL %s: tx/busy/ready=%b required 101", tag, {tx_pin, busy, req_ready});
      end
  endtask

  // Called one cycle after acceptance; walks the whole 8N1 frame cycle by cycle.
  task automatic run_frame(input logic [7:0] exp, input string tag,
                           input bit noise, input bit clear_end);
    logic [9:0] bits;
    int         bad_k;
    logic [2:0] bad_obs;
    bits    = {1'b1, exp, 1'b0};
    bad_k   = -1;
    bad_obs = 3'b000;
    checks++;
    assert ({tx_pin, busy, req_ready} === 3'b010)
      else begin
        errors++;
        $error("FAIL %s start: tx/busy/ready=%b required 010", tag, {tx_pin, busy, req_ready});
      end
    for (int k = 0; k < FRAME; k++) begin
      if (bad_k < 0 && ({tx_pin, busy, req_ready} !== {bits[k / DIV], 2'b10})) begin
        bad_k   = k;
        bad_obs = {tx_pin, busy, req_ready};
      end
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_motor = 2'($urandom_range(0, 3));
        req_servo = 2'($urandom_range(0, 3));
      end
      step();
    end
    checks++;
    assert (bad_k === -1)
      else begin
        errors++;
        $error("FAIL %s byte %h: first bad cycle %0d tx/busy/ready=%b required -1",
               tag, exp, bad_k, bad_obs);
      end
    if (clear_end) req_valid = 1'b0;
    check_idle({tag, "_end"});
  endtask

  task automatic send(input int m, input int s, input logic [7:0] exp,
                      input string tag, input bit noise);
    req_motor = 2'(m);
    req_servo = 2'(s);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    run_frame(exp, tag, noise, 1'b1);
  endtask

  task automatic idle_watch(input int n, input string tag);
    int         bad_k;
    logic [2:0] bad_obs;
    bad_k   = -1;
    bad_obs = 3'b000;
    for (int k = 0; k < n; k++) begin
      step();
      if (bad_k < 0 && ({tx_pin, busy, req_ready} !== 3'b101)) begin
        bad_k   = k;
        bad_obs = {tx_pin, busy, req_ready};
      end
    end
    checks++;
    assert (bad_k === -1)
      else begin
        errors++;
        $error("FAIL %s: first non-idle cycle %0d tx/busy/ready=%b required -1", tag, bad_k, bad_obs);
      end
  endtask

  initial begin
    int m, s, gap;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_motor = 2'd0;
    req_servo = 2'd0;
    #13;
    check_idle("reset_hold");
    step();
    rst = 1'b0;
    check_idle("reset_release");
    step();
    check_idle("post_reset_cycle1");

    // Spec reference bytes, inputs scrambled while busy.
    send(1, 1, 8'h6C, "fwd_left", 1'b1);
    send(2, 2, 8'hD8, "bwd_right", 1'b1);
    send(3, 3, 8'h14, "halt_straight", 1'b1);

    // Back-to-back: req_valid stays high across the first frame.
    req_motor = 2'd1;
    req_servo = 2'd2;
    req_valid = 1'b1;
    step();
    req_motor = 2'd2;
    req_servo = 2'd1;
    run_frame(model_byte(1, 2), "b2b_first", 1'b0, 1'b0);
    step();
    run_frame(model_byte(2, 1), "b2b_second", 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      m   = int'($urandom_range(0, 3));
      s   = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 5));
      if (gap > 0) idle_watch(gap, "rand_gap");
      send(m, s, model_byte(m, s), $sformatf("rand%0d_m%0d_s%0d", i, m, s), 1'b1);
    end

`ifdef REMOTE_CMD_KEEPALIVE_EN
    send(1, 1, 8'h6C, "ka_seed", 1'b0);
    idle_watch(KA - 1, "ka_wait");
    step();
    run_frame(8'h6C, "ka_resend", 1'b0, 1'b1);
    idle_watch(KA - 1, "ka_wait2");
    send(2, 2, 8'hD8, "ka_req_wins", 1'b0);
`else
    send(1, 1, 8'h6C, "nka_seed", 1'b0);
    idle_watch(3 * KA, "nka_no_resend");
`endif

    // Abort a frame during data bit 4.
    req_motor = 2'd2;
    req_servo = 2'd3;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (5 * DIV + DIV / 2) step();
    rst = 1'b1;
    #1;
    check_idle("abort_immediate");
    step();
    step();
    check_idle("abort_held");
    rst = 1'b0;
`ifdef REMOTE_CMD_KEEPALIVE_EN
    idle_watch(KA - 1, "abort_quiet");
    step();
    run_frame(8'h00, "ka_after_reset", 1'b0, 1'b1);
`else
    idle_watch(2 * FRAME, "abort_quiet");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/remote_cmd_tx.md
REMOTE_CMD_TX -- requirements
Module: remote_cmd_tx

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100_000_000, meaning sys_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 921600, meaning UART bit rate.
REQ-003 SHALL have parameter KEEPALIVE_CYCLES, default 10_000_000, meaning idle sys_clk cycles before a keepalive resend.
REQ-004 SHALL have port sys_clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  meaning a command is offered.
REQ-007 SHALL have port req_ready  output  1  meaning the block accepts a command this cycle.
REQ-008 SHALL have port req_motor  input  2  meaning 0 halt, 1 forward, 2 backward, 3 halt.
REQ-009 SHALL have port req_servo  input  2  meaning 0 hold, 1 left, 2 right, 3 straight.
REQ-010 SHALL have port tx_pin  output  1  meaning UART serial line, idle high.
REQ-011 SHALL have port busy  output  1  meaning a frame is on the line.

Function
REQ-012 SHALL encode the command byte as motor code in [7:5], servo code in [4:2] and 2'b00 in [1:0].
REQ-013 SHALL use motor codes forward 3'b011, backward 3'b110 and halt 3'b000.
REQ-014 SHALL use servo codes left 3'b011, right 3'b110, straight 3'b101 and hold 3'b000.
REQ-015 SHALL accept a command on any rising edge with req_valid and req_ready both high, latching the encoded byte.
REQ-016 SHALL drive req_ready high only in IDLE and low from the cycle after acceptance until the stop bit completes.
REQ-017 SHALL implement states IDLE -> START -> DATA -> STOP -> IDLE.
REQ-018 SHALL drive tx_pin low (start bit) in the cycle after acceptance, so acceptance-to-start-bit latency is 1 cycle.
REQ-019 SHALL set bit period DIV = SYS_CLK_FREQ / BAUD_RATE, integer truncated (108 at the defaults), with every bit lasting exactly DIV cycles.
REQ-020 SHALL send 8N1: one start bit, 8 data bits LSB first, one stop bit high, for 10*DIV cycles per frame.
REQ-021 SHALL hold busy high for exactly the START, DATA and STOP states.
REQ-022 SHALL restore req_ready to high in the first cycle after the stop bit ends, allowing back-to-back frames with no idle gap.
REQ-023 SHALL ignore input changes while busy, holding the latched byte unchanged.
REQ-024 SHALL retain the last transmitted byte as last_cmd, which equals 8'h00 after reset.

Reset
REQ-025 SHALL force the following values immediately while rst is high: tx_pin=1, busy=0, state=IDLE, last_cmd=8'h00, all counters=0.
REQ-026 SHALL assert req_ready=1 during reset so that it is valid in the first cycle after release.
REQ-027 SHALL abort any frame in flight on reset, returning the line high at once and never resuming the aborted frame.

Configuration
REQ-028 SHALL, when macro REMOTE_CMD_KEEPALIVE_EN is defined, count consecutive IDLE cycles and resend last_cmd once the count reaches KEEPALIVE_CYCLES.
REQ-029 SHALL, when keepalive is enabled, clear the idle counter on every frame start; a request at the expiry cycle wins and the keepalive is not sent.
REQ-030 SHALL, without REMOTE_CMD_KEEPALIVE_EN, omit the keepalive counter and send frames only on accepted requests.

Structure
REQ-031 SHALL place motor/servo code constants and the state enum in shared package remote_cmd_pkg.
REQ-032 SHALL place the DIV-cycle bit timer in sub-module remote_cmd_baud, which has a restart input and a one-cycle bit_tick output.

Verification
REQ-033 SHALL check that req_motor=1, req_servo=1 produces byte 0x6C on tx_pin (LSB first), with start bit 1 cycle after acceptance and frame length 1080 cycles.
REQ-034 SHALL check that req_motor=2, req_servo=2 produces 0xD8, and that req_motor=3, req_servo=3 produces 0x14.
REQ-035 SHALL check that holding req_valid high for two commands produces back-to-back frames with req_ready high for exactly 1 cycle between them.
REQ-036 SHALL check that asserting rst at bit 4 of a frame sets tx_pin=1, busy=0, req_ready=1 immediately, and that no further edges appear.
REQ-037 SHALL check, with KEEPALIVE_EN and KEEPALIVE_CYCLES=200, that after a 0x6C frame and 200 idle cycles a 0x6C resend occurs, and that a request at cycle 200 sends only the new byte.
REQ-038 SHALL check, with KEEPALIVE_EN set and no request after reset, that byte 0x00 is sent after KEEPALIVE_CYCLES.
